// File: rtl/imem_loader_pkg.sv
// Shared definitions for the UART-to-instruction-memory loader.
package imem_loader_pkg;

   localparam int INSTR_W = 32;
   localparam logic [INSTR_W-1:0] TERMINATOR_DEFAULT = 32'hFFFF_FFFF;

   // Loader FSM: loading words, or finished (absorbing until reset).
   typedef enum logic {
      S_LOAD = 1'b0,
      S_DONE = 1'b1
   } state_e;

endpackage : imem_loader_pkg

// File: rtl/uart_imem_loader.sv
// Packs received UART bytes little-endian into 32-bit words and writes them
// to consecutive instruction-memory addresses until the terminator word is
// seen or the memory is full.
module uart_imem_loader
   import imem_loader_pkg::*;
#(
   parameter int                 ADDR_W         = 10,
   parameter int                 TIMEOUT_CYCLES = 200000,
   parameter logic [INSTR_W-1:0] TERMINATOR     = TERMINATOR_DEFAULT
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               uart_rx_valid,
   input  logic [7:0]         uart_rx_data,
   input  logic               uart_rx_break,
   output logic               imem_wr_en,
   output logic [ADDR_W-1:0]  imem_wr_addr,
   output logic [INSTR_W-1:0] imem_wr_data,
   output logic               write_done,
   output logic               load_overflow
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   // Last count value before the partial word is abandoned; reaching
   // TIMEOUT_CYCLES happens on the edge where this value is observed idle.
   localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_e              state_q, state_d;
   logic [1:0]          byte_idx_q, byte_idx_d;
   logic [INSTR_W-1:0]  shift_q, shift_d;
   logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]    idle_q, idle_d;
   logic                wr_en_q, wr_en_d;
   logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
   logic [INSTR_W-1:0]  wr_data_q, wr_data_d;
   logic                done_q, done_d;
   logic                ovf_q, ovf_d;

   logic [INSTR_W-1:0]  word_w;

   // The word as it stands once the incoming byte lands in the top lane.
   assign word_w = {uart_rx_data, shift_q[23:0]};

   // Next-state logic: byte assembly, word completion, BREAK and timeout.
   always_comb begin
      // NOTE: every always_comb target gets a default first, so no path can
      // leave it unassigned and infer a latch.
      state_d    = state_q;
      byte_idx_d = byte_idx_q;
      shift_d    = shift_q;
      wr_ptr_d   = wr_ptr_q;
      idle_d     = idle_q;
      wr_en_d    = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      done_d     = done_q;
      ovf_d      = ovf_q;

      if (state_q == S_LOAD) begin
         if (uart_rx_break) begin
            // BREAK discards the partial word and wins over a coincident byte.
            byte_idx_d = 2'd0;
            idle_d     = '0;
         end else if (uart_rx_valid) begin
            shift_d[8*byte_idx_q +: 8] = uart_rx_data;
            byte_idx_d = byte_idx_q + 2'd1;
            idle_d     = '0;
            if (byte_idx_q == 2'd3) begin
               if (word_w == TERMINATOR) begin
                  done_d  = 1'b1;
                  state_d = S_DONE;
               end else begin
                  wr_en_d   = 1'b1;
                  wr_addr_d = wr_ptr_q;
                  wr_data_d = word_w;
                  if (&wr_ptr_q) begin
                     // Last slot written: stop rather than wrap.
                     ovf_d   = 1'b1;
                     done_d  = 1'b1;
                     state_d = S_DONE;
                  end else begin
                     wr_ptr_d = wr_ptr_q + 1'b1;
                  end
               end
            end
         end else if (byte_idx_q != 2'd0) begin
            if (idle_q == IDLE_LAST) begin
               byte_idx_d = 2'd0;
               idle_d     = '0;
            end else begin
               idle_d = idle_q + 1'b1;
            end
         end
      end
   end

   // State and output registers, cleared asynchronously by resetn.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= S_LOAD;
         byte_idx_q <= 2'd0;
         shift_q    <= '0;
         wr_ptr_q   <= '0;
         idle_q     <= '0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         done_q     <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values, independent of statement order.
         state_q    <= state_d;
         byte_idx_q <= byte_idx_d;
         shift_q    <= shift_d;
         wr_ptr_q   <= wr_ptr_d;
         idle_q     <= idle_d;
         wr_en_q    <= wr_en_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         done_q     <= done_d;
         ovf_q      <= ovf_d;
      end
   end

   assign imem_wr_en    = wr_en_q;
   assign imem_wr_addr  = wr_addr_q;
   assign imem_wr_data  = wr_data_q;
   assign write_done    = done_q;
   assign load_overflow = ovf_q;

endmodule : uart_imem_loader

// File: doc/uart_imem_loader.md
# uart_imem_loader

Byte-to-word assembler between the UART receiver and the instruction memory in `wrapper`. It consumes received bytes (`uart_rx_valid`/`uart_rx_data`) and packs them little-endian into 32-bit instruction words. Each complete word is written to consecutive instruction-memory addresses. On the terminator word 0xFFFFFFFF it raises `write_done`, which releases the core from reset.

## Interface
- `ADDR_W`, default 10: word-address width; memory depth is 2**ADDR_W words.
- `TIMEOUT_CYCLES`, default 200000: idle clocks after which a partial word is discarded.
- `TERMINATOR`, default 32'hFFFF_FFFF: end-of-program marker word.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `resetn`  in  1  asynchronous, active-low reset.
- `uart_rx_valid`  in  1  one-cycle strobe; `uart_rx_data` is valid.
- `uart_rx_data`  in  8  received byte.
- `uart_rx_break`  in  1  BREAK detected on the line.
- `imem_wr_en`  out  1  one-cycle write strobe.
- `imem_wr_addr`  out  ADDR_W  word address.
- `imem_wr_data`  out  32  instruction word.
- `write_done`  out  1  load complete; sticky until reset.
- `load_overflow`  out  1  memory filled before the terminator; sticky.

## Operation
- The FSM has two states: `S_LOAD` (reset state) and `S_DONE`.
- **Byte assembly in `S_LOAD`:** a 2-bit `byte_idx` and a 32-bit `shift` register.
  - Each `uart_rx_valid` stores the byte into `shift[8*byte_idx +: 8]` and increments `byte_idx`.
  - First byte → bits [7:0]; fourth byte → bits [31:24].
- **Word completion:** on the byte with `byte_idx==3`, the assembled word W is evaluated on the same edge.
  - W == `TERMINATOR`: no write; `write_done`←1; go to `S_DONE`.
  - Otherwise: `imem_wr_en`←1, `imem_wr_data`←W, `imem_wr_addr`←`wr_ptr`, then `wr_ptr` increments.
  - `byte_idx` returns to 0 in both cases.
- **Overflow:** when the write lands at `wr_ptr == 2**ADDR_W-1`, the write still occurs. Then `load_overflow`←1, `write_done`←1, and the FSM goes to `S_DONE`. There is no wrap-around.
- **BREAK:** `uart_rx_break` high in `S_LOAD` clears `byte_idx` (partial word discarded). `wr_ptr` is unchanged. A BREAK in the same cycle as `uart_rx_valid` takes priority and the byte is dropped.
- **Timeout:** the idle counter resets on every accepted byte. It counts only while `byte_idx != 0`. When it reaches `TIMEOUT_CYCLES`, `byte_idx` clears and the partial word is discarded.
- **`S_DONE`:** absorbing state. All UART input is ignored and `imem_wr_en` stays 0. Exit is via `resetn` only.

## Timing
- **Reset values:** `imem_wr_en`=0, `imem_wr_addr`=0, `imem_wr_data`=0, `write_done`=0, `load_overflow`=0. Internal: `wr_ptr`=0, `byte_idx`=0, idle counter=0, state `S_LOAD`.
- **Write latency:** 4th byte strobe at edge N → `imem_wr_en` high for exactly the cycle after N. Addr/data are registered with it and hold until the next write.
- **Terminator latency:** `write_done` rises in the cycle after the terminator's 4th byte.
- **Back-to-back bytes:** strobes on consecutive cycles are all accepted. A new byte during the `imem_wr_en` cycle is accepted into the next word.
- **Reset mid-word:** asynchronous reset clears all state immediately, including the partial word.
- **Timeout boundary:** a byte arriving on the same edge the counter hits `TIMEOUT_CYCLES` is accepted; the timeout is suppressed.
- **Counter widths:** `wr_ptr` is ADDR_W bits; the idle counter is `$clog2(TIMEOUT_CYCLES+1)` bits.

## Structure
- **Shared package `imem_loader_pkg`:** FSM state enum (`S_LOAD`, `S_DONE`), `TERMINATOR` default, and the `INSTR_W=32` constant.
- **Single module:** no sub-module. The idle counter is simple enough to stay inline.
- **Integration:** instantiated in `wrapper` between the UART RX and the instruction memory write port. `write_done` is exported to the wrapper port of the same name.

## Test plan
- **Basic load:** bytes 13,01,01,FD, then 23,26,81,02, then FF×4 → writes addr0=FD010113 and addr1=02812623. `write_done`=1 one cycle after the last FF; `load_overflow`=0.
- **Timeout:** bytes 93,07 then idle for `TIMEOUT_CYCLES`+1 clocks, then 6F,00,00,00 → single write addr0=0000006F.
- **BREAK mid-word:** send AA,BB, assert `uart_rx_break` for 1 cycle, then 01,02,03,04 → addr0=04030201. Repeat with BREAK coincident with a valid strobe; that byte is dropped.
- **Overflow (ADDR_W=2):** send 5 non-terminator words → writes at addr0..3 only. `load_overflow`=1 and `write_done`=1 after the 4th write; the 5th word produces no write.
- **Post-done:** after `write_done`, send 4 more bytes → no `imem_wr_en`; outputs stable.
- **Reset mid-word:** send 2 bytes, pulse `resetn` low, then send 11,22,33,44 → addr0=44332211; all outputs at reset values during reset.
